// File: rtl/ap_ctrl_driver.sv
// Batch driver for an ap_ctrl_hs kernel: issues cmd_runs back-to-back transactions,
// tracks per-transaction latency statistics, total batch cycles and sticky error flags.
module ap_ctrl_driver #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000000
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             cmd_start,
  input  logic [15:0]      cmd_runs,
  output logic             busy,
  output logic             batch_done,
  output logic             kern_ap_start,
  input  logic             kern_ap_ready,
  input  logic             kern_ap_done,
  output logic             kern_ap_continue,
  output logic [15:0]      runs_done,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] total_cycles,
  output logic             timeout_err,
  output logic             proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_DONE, S_FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic [15:0]      runs_q;
  logic [15:0]      runs_inc;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] cur_lat;
  logic             zero_done_q;
  logic             accept, in_txn, at_timeout;
  logic             txn_done, proto_hit, tmo_hit;

  assign accept     = (state_q == S_IDLE) && cmd_start;
  assign in_txn     = (state_q == S_ISSUE) || (state_q == S_WAIT_DONE);
  // Latency of the current cycle if the transaction ended now (start cycle counts as 1).
  assign cur_lat    = (lat_cnt == CNT_MAX) ? lat_cnt : lat_cnt + 1'b1;
  assign at_timeout = cur_lat >= TO_VAL;
  assign runs_inc   = runs_done + 16'd1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    txn_done  = 1'b0;
    proto_hit = 1'b0;
    tmo_hit   = 1'b0;
    case (state_q)
      S_IDLE: if (cmd_start && cmd_runs != 16'd0) state_d = S_ISSUE;
      S_ISSUE: begin
        if (kern_ap_done) begin
          txn_done  = 1'b1;
          proto_hit = !kern_ap_ready;
        end else if (at_timeout) begin
          tmo_hit = 1'b1;
        end else if (kern_ap_ready) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        proto_hit = kern_ap_ready;
        if (kern_ap_done)    txn_done = 1'b1;
        else if (at_timeout) tmo_hit  = 1'b1;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (txn_done) state_d = (runs_inc < runs_q) ? S_ISSUE : S_FINISH;
    if (tmo_hit)  state_d = S_FINISH;
  end

  always_comb begin
    kern_ap_start    = (state_q == S_ISSUE);
    busy             = (state_q != S_IDLE);
    batch_done       = (state_q == S_FINISH) || zero_done_q;
    kern_ap_continue = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding evaluation-order races.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      runs_q       <= '0;
      runs_done    <= '0;
      lat_cnt      <= '0;
      lat_last     <= '0;
      lat_min      <= CNT_MAX;
      lat_max      <= '0;
      total_cycles <= '0;
      timeout_err  <= 1'b0;
      proto_err    <= 1'b0;
      zero_done_q  <= 1'b0;
    end else if (accept) begin
      runs_q       <= cmd_runs;
      runs_done    <= '0;
      lat_cnt      <= '0;
      lat_last     <= '0;
      lat_min      <= CNT_MAX;
      lat_max      <= '0;
      // The accept cycle stands in for the FINISH cycle, which holds the count frozen.
      total_cycles <= (cmd_runs != 16'd0) ? CNT_W'(1) : '0;
      timeout_err  <= 1'b0;
      proto_err    <= 1'b0;
      zero_done_q  <= (cmd_runs == 16'd0);
    end else begin
      zero_done_q <= 1'b0;
      if (in_txn) begin
        if (total_cycles != CNT_MAX) total_cycles <= total_cycles + 1'b1;
        lat_cnt <= txn_done ? '0 : cur_lat;
        if (proto_hit) proto_err   <= 1'b1;
        if (tmo_hit)   timeout_err <= 1'b1;
        if (txn_done) begin
          runs_done <= runs_inc;
          lat_last  <= cur_lat;
          if (cur_lat < lat_min) lat_min <= cur_lat;
          if (cur_lat > lat_max) lat_max <= cur_lat;
        end
      end
    end
  end

endmodule
